// File: rtl/mem_port_arbiter_if.sv
// rtl/mem_port_arbiter_if.sv - fetch/data/memory port bundle for mem_port_arbiter
interface mem_port_arbiter_if #(
    parameter int BIT_WIDTH = 32
);
    // fetch side
    logic [BIT_WIDTH-1:0] iad;
    logic                 ireq;
    logic [BIT_WIDTH-1:0] idt;
    logic                 acki_n;
    // data side
    logic [BIT_WIDTH-1:0] dad;
    logic                 dreq;
    logic                 dwrite;
    logic [1:0]           dsize;
    logic [BIT_WIDTH-1:0] dwdata;
    logic [BIT_WIDTH-1:0] drdata;
    logic                 ackd_n;
    // unified memory side
    logic [BIT_WIDTH-1:0] mad;
    logic                 mreq;
    logic                 mwrite;
    logic [1:0]           msize;
    logic [BIT_WIDTH-1:0] mwdata;
    logic [BIT_WIDTH-1:0] mrdata;
    logic                 mack_n;
    logic                 busy;

    // arbiter view
    modport slave (
        input  iad, ireq, dad, dreq, dwrite, dsize, dwdata, mrdata, mack_n,
        output idt, acki_n, drdata, ackd_n, mad, mreq, mwrite, msize, mwdata, busy
    );

    // core + memory view
    modport master (
        output iad, ireq, dad, dreq, dwrite, dsize, dwdata, mrdata, mack_n,
        input  idt, acki_n, drdata, ackd_n, mad, mreq, mwrite, msize, mwdata, busy
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - fetch/data arbiter onto one memory port; optional ARB_STARVE_GUARD_EN starvation guard
module mem_port_arbiter #(
    parameter int BIT_WIDTH    = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rst,
    mem_port_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IBUSY = 2'd1,
        DBUSY = 2'd2
    } state_t;

    state_t               state_q;
    logic                 mreq_q;
    logic                 mwrite_q;
    logic [1:0]           msize_q;
    logic [BIT_WIDTH-1:0] mad_q;
    logic [BIT_WIDTH-1:0] mwdata_q;

    logic                 fetch_forced;
    logic                 grant_d;
    logic                 grant_i;

`ifdef ARB_STARVE_GUARD_EN
    logic [3:0] starve_cnt_q;

    // a waiting fetch overrides data priority once data has won STARVE_LIMIT times
    assign fetch_forced = bus.ireq && (starve_cnt_q == 4'(STARVE_LIMIT));

    // count data grants that passed over a pending fetch; a fetch grant clears it
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            starve_cnt_q <= 4'd0;
        end else if (grant_d && bus.ireq && (starve_cnt_q != 4'(STARVE_LIMIT))) begin
            starve_cnt_q <= starve_cnt_q + 4'd1;
        end else if (grant_i) begin
            starve_cnt_q <= 4'd0;
        end
    end
`else
    // strict data priority: never forced (comparison is always false for a legal limit)
    assign fetch_forced = (STARVE_LIMIT < 0);
`endif

    // arbitration happens only in IDLE; data wins unless the guard forces the fetch
    always_comb begin
        grant_d = 1'b0;
        grant_i = 1'b0;
        if (state_q == IDLE) begin
            grant_d = bus.dreq && !fetch_forced;
            grant_i = bus.ireq && !grant_d;
        end
    end

    // transaction FSM; memory-side fields are latched at grant and held until the ack edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            mreq_q   <= 1'b0;
            mwrite_q <= 1'b0;
            msize_q  <= 2'b00;
            mad_q    <= '0;
            mwdata_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_d) begin
                        state_q  <= DBUSY;
                        mreq_q   <= 1'b1;
                        mad_q    <= bus.dad;
                        mwrite_q <= bus.dwrite;
                        msize_q  <= bus.dsize;
                        mwdata_q <= bus.dwdata;
                    end else if (grant_i) begin
                        state_q  <= IBUSY;
                        mreq_q   <= 1'b1;
                        mad_q    <= bus.iad;
                        mwrite_q <= 1'b0;
                        msize_q  <= 2'b00;
                        mwdata_q <= '0;
                    end
                end
                IBUSY, DBUSY: begin
                    // completes even if the requester already dropped its request
                    if (!bus.mack_n) begin
                        state_q <= IDLE;
                        mreq_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    mreq_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.mreq   = mreq_q;
    assign bus.mad    = mad_q;
    assign bus.mwrite = mwrite_q;
    assign bus.msize  = msize_q;
    assign bus.mwdata = mwdata_q;
    assign bus.busy   = (state_q != IDLE);

    // acks are forwarded combinationally to whichever side owns the port
    assign bus.acki_n = !((state_q == IBUSY) && !bus.mack_n);
    assign bus.ackd_n = !((state_q == DBUSY) && !bus.mack_n);
    assign bus.idt    = bus.mrdata;
    assign bus.drdata = bus.mrdata;
endmodule
